// File: rtl/bitty_pkg.sv
// Shared encoder/decoder definitions: instruction width, field bit positions,
// captured-field struct and the encoder phase enum.
package bitty_pkg;

    localparam int INST_W   = 16;
    localparam int RX_MSB   = 15;
    localparam int RX_LSB   = 13;
    localparam int RY_MSB   = 12;
    localparam int RY_LSB   = 10;
    localparam int SEL_MSB  = 5;
    localparam int SEL_LSB  = 2;
    localparam int MODE_BIT = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    typedef struct packed {
        logic [RX_MSB-RX_LSB:0]   rx;
        logic [RY_MSB-RY_LSB:0]   ry;
        logic [SEL_MSB-SEL_LSB:0] alu_sel;
        logic                     mode;
    } fields_t;

endpackage

// File: rtl/inst_pack.sv
// Combinational packer: places captured fields into the instruction word;
// bits not owned by a field are driven to zero.
module inst_pack
    import bitty_pkg::*;
(
    input  fields_t           fld,
    output logic [INST_W-1:0] inst
);

    always_comb begin
        inst                   = '0;
        inst[RX_MSB:RX_LSB]    = fld.rx;
        inst[RY_MSB:RY_LSB]    = fld.ry;
        inst[SEL_MSB:SEL_LSB]  = fld.alu_sel;
        inst[MODE_BIT]         = fld.mode;
    end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder: accepts fields in IDLE, then steps LOAD_A..DONE one cycle each (6-cycle issue).
// Optional INST_ENCODER_COUNT_EN adds issued_cnt, counting DONE cycles.
module inst_encoder
    import bitty_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        rx,
    input  logic [2:0]        ry,
    input  logic [3:0]        alu_sel,
    input  logic              mode,
    output logic [INST_W-1:0] inst,
    output logic              number,
    output logic              en_a,
    output logic              en_b,
    output logic              en_s,
    output logic              en_rx,
`ifdef INST_ENCODER_COUNT_EN
    output logic [15:0]       issued_cnt,
`endif
    output logic              done
);

    state_t  state_q, state_d;
    fields_t fld_q, fld_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            fld_q   <= '0;
        end else begin
            state_q <= state_d;
            fld_q   <= fld_d;
        end
    end

    // Fields are only captured on acceptance, so inputs seen while busy never reach fld_q.
    always_comb begin
        state_d = state_q;
        fld_d   = fld_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d       = ST_LOAD_A;
                    fld_d.rx      = rx;
                    fld_d.ry      = ry;
                    fld_d.alu_sel = alu_sel;
                    fld_d.mode    = mode;
                end
            end
            ST_LOAD_A: state_d = ST_LOAD_B;
            ST_LOAD_B: state_d = ST_EXEC;
            ST_EXEC:   state_d = ST_WB;
            ST_WB:     state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        number   = 1'b0;
        en_a     = 1'b0;
        en_b     = 1'b0;
        en_s     = 1'b0;
        en_rx    = 1'b0;
        done     = 1'b0;
        case (state_q)
            ST_IDLE:   in_ready = 1'b1;
            ST_LOAD_A: begin en_a = 1'b1; number = 1'b1; end
            ST_LOAD_B: en_b = 1'b1;
            ST_EXEC:   en_s = 1'b1;
            ST_WB:     begin en_rx = 1'b1; number = 1'b1; end
            ST_DONE:   done = 1'b1;
            default:   in_ready = 1'b0;
        endcase
    end

    inst_pack u_pack (
        .fld  (fld_q),
        .inst (inst)
    );

`ifdef INST_ENCODER_COUNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_DONE) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign issued_cnt = cnt_q;
`endif

endmodule
